dmem_pipe: RTL
==============

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL provide parameter DEPTH, default 2048, number of 32-bit words held.
REQ-002 SHALL provide parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL provide parameter LAT, default 1, legal 1..4, read latency in cycles from acceptance to response.
REQ-004 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port req_valid  input  1  request present.
REQ-007 SHALL provide port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL provide port req_type  input  3  access type: W=000, H=001, HU=010, B=011, BU=100.
REQ-010 SHALL provide port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL provide port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL provide port rsp_valid  output  1  response present.
REQ-013 SHALL provide port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL provide port rsp_rdata  output  32  load data, extended per type; 0 for stores and errors.
REQ-015 SHALL provide port rsp_err  output  1  request was misaligned, out of range or illegal type.

Function
REQ-016 Acceptance SHALL occur on a rising edge with req_valid && req_ready; one request per cycle max.
REQ-017 Every accepted request (load or store) SHALL yield exactly one response, in acceptance order.
REQ-018 Word index SHALL be req_addr[ADDR_W-1:2]; byte lane req_addr[1:0]; little-endian lanes.
REQ-019 Error SHALL be flagged when: W with addr[1:0]!=0; H/HU with addr[0]=1; word index >= DEPTH; req_type > 100.
REQ-020 Errored requests SHALL not modify memory.
REQ-021 Stores SHALL write memory at the accepting edge: W all lanes, H lanes addr[1]*2+{0,1}, B lane addr[1:0]; other lanes unchanged.
REQ-022 Loads SHALL sample memory at the accepting edge, so a load accepted after a store to the same word returns the stored data.
REQ-023 Load extension: H/B sign-extend from bit 15/7; HU/BU zero-extend; W unmodified.
REQ-024 A response SHALL become visible LAT cycles after acceptance when the output queue is empty and rsp_ready has been high.
REQ-025 Response path SHALL be LAT pipeline stages feeding an output FIFO of depth LAT+1.
REQ-026 A credit counter SHALL track accepted-but-not-consumed responses, 0..LAT+1; req_ready = (count < LAT+1) && !rst.
REQ-027 Simultaneous accept and consume SHALL leave the count unchanged; the FIFO SHALL never overflow or drop.
REQ-028 With rsp_ready held high and req_valid held high, throughput SHALL be one response per cycle.
REQ-029 rsp_valid, rsp_rdata, rsp_err SHALL stay stable while rsp_valid && !rsp_ready.

Reset
REQ-030 rst SHALL asynchronously clear pipeline valids, FIFO pointers and credit count to 0.
REQ-031 During and after reset: rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=0 while rst high, 1 the first cycle after.
REQ-032 In-flight requests at reset SHALL be discarded with no response; completed stores SHALL persist.
REQ-033 Memory contents SHALL not be reset.

Structure
REQ-034 The access-type encodings and their widths SHALL live in the shared package dmem_pkg.
REQ-035 Load extension and lane steering SHALL be one sub-module, dmem_lane_align (combinational).
REQ-036 Memory SHALL be DEPTH x 32 with per-byte write enables, inferable as block RAM.

Verification
REQ-037 LAT=1: store W 0xDEADBEEF @0x10, then load W @0x10 -> two responses, second rdata 0xDEADBEEF, err 0.
REQ-038 Store B 0x80 @0x13, load B @0x13 -> 0xFFFFFF80; load BU @0x13 -> 0x00000080; load W @0x10 -> 0x80ADBEEF.
REQ-039 Load H @0x11, store W @0x12, access @(DEPTH*4) -> each err=1, rdata 0, memory unchanged.
REQ-040 LAT=3, rsp_ready low for 10 cycles with req_valid high -> exactly 4 accepted, req_ready low, then 4 in-order responses on release.
REQ-041 LAT=2, back-to-back loads with rsp_ready high -> rsp_valid high every cycle, first response 2 cycles after first accept.
REQ-042 Assert rst with 3 requests in flight -> no responses emerge, count 0, prior stores still readable.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared access-type encodings, widths and response metadata for the data memory pipe.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        ACC_W  = 3'b000,
        ACC_H  = 3'b001,
        ACC_HU = 3'b010,
        ACC_B  = 3'b011,
        ACC_BU = 3'b100
    } acc_type_e;

    // Per-request information carried alongside the read word to the response.
    typedef struct packed {
        logic              err;
        logic              we;
        logic [TYPE_W-1:0] typ;
        logic [LANE_W-1:0] lane;
    } rsp_meta_t;

    function automatic logic is_half(input logic [TYPE_W-1:0] t);
        return (t == ACC_H) || (t == ACC_HU);
    endfunction

    function automatic logic is_byte(input logic [TYPE_W-1:0] t);
        return (t == ACC_B) || (t == ACC_BU);
    endfunction

    function automatic logic type_legal(input logic [TYPE_W-1:0] t);
        return t <= TYPE_W'(ACC_BU);
    endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// Request/response bus of the data memory pipe.
interface dmem_pipe_if #(
    parameter int unsigned ADDR_W = 32
);
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [TYPE_W-1:0] req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for stores and lane select plus extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [TYPE_W-1:0] st_type,
    input  logic [LANE_W-1:0] st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [LANES-1:0]  st_be_c,
    output logic [DATA_W-1:0] st_word_c,
    input  logic [TYPE_W-1:0] ld_type,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [15:0] ld_shift;

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        st_be_c   = '0;
        st_word_c = st_wdata;
        if (st_type == ACC_W) begin
            st_be_c = '1;
        end else if (is_half(st_type)) begin
            st_be_c   = st_lane[1] ? 4'b1100 : 4'b0011;
            st_word_c = {2{st_wdata[15:0]}};
        end else if (is_byte(st_type)) begin
            st_be_c   = LANES'(1) << st_lane;
            st_word_c = {4{st_wdata[7:0]}};
        end
    end

    // Bring the addressed lane down to bit 0 and extend to a full word.
    always_comb begin
        ld_shift  = 16'(ld_word >> {ld_lane, 3'b000});
        ld_data_c = ld_word;
        case (ld_type)
            ACC_H:   ld_data_c = {{16{ld_shift[15]}}, ld_shift};
            ACC_HU:  ld_data_c = {16'h0000, ld_shift};
            ACC_B:   ld_data_c = {{24{ld_shift[7]}}, ld_shift[7:0]};
            ACC_BU:  ld_data_c = {24'h000000, ld_shift[7:0]};
            default: ld_data_c = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined byte-addressable data memory: LAT read stages feeding a LAT+1 deep
// response FIFO, with credit-based request flow control.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_pipe_if.slave  bus
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam int unsigned FIFO_D = LAT + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_D);
    localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [WIDX_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              req_err;
    logic              accept;
    logic              consume;
    logic              wr_en;
    logic [LANES-1:0]  st_be;
    logic [DATA_W-1:0] st_word;
    logic [CNT_W-1:0]  credit_q;

    logic [LAT-1:0]    pipe_v;
    rsp_meta_t         pipe_meta [LAT];
    logic [DATA_W-1:0] pipe_word [LAT];

    rsp_meta_t         fifo_meta [FIFO_D];
    logic [DATA_W-1:0] fifo_word [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    rsp_meta_t         head_meta;
    logic [DATA_W-1:0] head_word;
    logic [DATA_W-1:0] ld_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign word_idx = bus.req_addr[ADDR_W-1:2];
    assign mem_idx  = IDX_W'(word_idx);
    assign req_err  = !type_legal(bus.req_type)
                   || ((bus.req_type == ACC_W) && (bus.req_addr[1:0] != 2'b00))
                   || (is_half(bus.req_type) && bus.req_addr[0])
                   || (word_idx >= WIDX_W'(DEPTH));

    assign bus.req_ready = (credit_q < CNT_W'(FIFO_D)) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_en         = accept && bus.req_we && !req_err;

    dmem_lane_align u_align (
        .st_type   (bus.req_type),
        .st_lane   (bus.req_addr[1:0]),
        .st_wdata  (bus.req_wdata),
        .st_be_c   (st_be),
        .st_word_c (st_word),
        .ld_type   (head_meta.typ),
        .ld_lane   (head_meta.lane),
        .ld_word   (head_word),
        .ld_data_c (ld_data)
    );

    // Byte-enabled write and registered read of the array; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(LANES); b++) begin
            if (wr_en && st_be[b]) begin
                mem[mem_idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
        pipe_word[0] <= mem[mem_idx];
    end

    // Read word travels down the remaining stages alongside its metadata.
    always_ff @(posedge clk) begin
        for (int s = 1; s < int'(LAT); s++) begin
            pipe_word[s] <= pipe_word[s-1];
        end
    end

    // Stage valids and request metadata; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int s = 0; s < int'(LAT); s++) begin
                pipe_meta[s] <= '0;
            end
        end else begin
            pipe_v[0]    <= accept;
            pipe_meta[0] <= '{err: req_err, we: bus.req_we, typ: bus.req_type,
                               lane: bus.req_addr[1:0]};
            for (int s = 1; s < int'(LAT); s++) begin
                pipe_v[s]    <= pipe_v[s-1];
                pipe_meta[s] <= pipe_meta[s-1];
            end
        end
    end

    // The last stage bypasses an empty FIFO; otherwise it queues behind older entries.
    assign fifo_empty    = (fifo_cnt == '0);
    assign bus.rsp_valid = !fifo_empty || pipe_v[LAT-1];
    assign consume       = bus.rsp_valid && bus.rsp_ready;
    assign push          = pipe_v[LAT-1] && !(fifo_empty && consume);
    assign pop           = consume && !fifo_empty;

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_meta[wr_ptr] <= pipe_meta[LAT-1];
            fifo_word[wr_ptr] <= pipe_word[LAT-1];
        end
    end

    // Credits bound accepted-but-unconsumed responses to the FIFO depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_q + CNT_W'(accept) - CNT_W'(consume);
        end
    end

    // Select the oldest pending response.
    always_comb begin
        head_meta = pipe_meta[LAT-1];
        head_word = pipe_word[LAT-1];
        if (!fifo_empty) begin
            head_meta = fifo_meta[rd_ptr];
            head_word = fifo_word[rd_ptr];
        end
    end

    assign bus.rsp_err   = bus.rsp_valid && head_meta.err;
    assign bus.rsp_rdata = (bus.rsp_valid && !head_meta.err && !head_meta.we) ? ld_data : '0;

endmodule
